dmem_bus_demux: RTL and testbench

Single-initiator, four-target data-memory bus router for the RV32 core's load/store path. It takes one core request, decodes the address into one of four target regions, and forwards the request to the selected target with a valid/ready handshake. It then waits for that target's response and returns it to the core as a one-cycle pulse. Unmapped addresses and unresponsive targets are terminated locally with an error response, so the core never hangs.

---
 rtl/dmem_bus_demux.sv | 166 ++++++++++++++++
 tb/tb_dmem_bus_demux.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus_demux.sv
// Data-memory bus router: one core initiator, four address-decoded targets.
// Unmapped addresses and stalled targets end in a local error response.
module dmem_bus_demux #(
    parameter logic [3:0]  REGION0 = 4'h0,
    parameter logic [3:0]  REGION1 = 4'h1,
    parameter logic [3:0]  REGION2 = 4'h2,
    parameter logic [3:0]  REGION3 = 4'h3,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [31:0]  req_addr,
    input  logic         req_we,
    input  logic [31:0]  req_wdata,
    input  logic [3:0]   req_be,
    output logic         resp_valid,
    output logic [31:0]  resp_rdata,
    output logic         resp_err,
    output logic [3:0]   t_req_valid,
    input  logic [3:0]   t_req_ready,
    output logic [31:0]  t_addr,
    output logic [31:0]  t_wdata,
    output logic         t_we,
    output logic [3:0]   t_be,
    input  logic [3:0]   t_resp_valid,
    input  logic [127:0] t_rdata
);

    localparam int unsigned    CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_sel;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic          r_we;
    logic [3:0]    r_be;
    logic [31:0]   r_rdata;
    logic          r_err;
    logic [CW-1:0] r_cnt;

    logic [3:0]    w_dec_sel;
    logic          w_dec_hit;
    logic          w_t_ready;
    logic          w_t_resp;
    logic          w_expired;
    logic [31:0]   w_sel_rdata;

    // Priority decode: the lowest-numbered matching region wins.
    always_comb begin
        w_dec_sel = '0;
        if (req_addr[31:28] == REGION0)
            w_dec_sel = 4'b0001;
        else if (req_addr[31:28] == REGION1)
            w_dec_sel = 4'b0010;
        else if (req_addr[31:28] == REGION2)
            w_dec_sel = 4'b0100;
        else if (req_addr[31:28] == REGION3)
            w_dec_sel = 4'b1000;
    end

    assign w_dec_hit = |w_dec_sel;
    assign w_t_ready = |(t_req_ready & r_sel);
    assign w_t_resp  = |(t_resp_valid & r_sel);
    assign w_expired = (r_cnt >= TO_LAST);

    always_comb begin
        w_sel_rdata = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (r_sel[i])
                w_sel_rdata = t_rdata[32*i +: 32];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Target progress in the final allowed cycle takes precedence over expiry.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid)
                    w_state_nxt = w_dec_hit ? S_REQ : S_DONE;
            end
            S_REQ: begin
                if (w_t_ready)
                    w_state_nxt = S_RESP;
                else if (w_expired)
                    w_state_nxt = S_DONE;
            end
            S_RESP: begin
                if (w_t_resp || w_expired)
                    w_state_nxt = S_DONE;
            end
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_sel   <= w_dec_sel;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_we    <= req_we;
                        r_be    <= req_be;
                        r_rdata <= '0;
                        r_err   <= ~w_dec_hit;
                        r_cnt   <= '0;
                    end
                end
                S_REQ: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (!w_t_ready && w_expired)
                        r_err <= 1'b1;
                end
                S_RESP: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_t_resp)
                        r_rdata <= r_we ? '0 : w_sel_rdata;
                    else if (w_expired)
                        r_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign req_ready   = (r_state == S_IDLE);
    assign resp_valid  = (r_state == S_DONE);
    assign resp_err    = resp_valid & r_err;
    assign resp_rdata  = resp_valid ? r_rdata : '0;
    assign t_req_valid = (r_state == S_REQ) ? r_sel : '0;
    assign t_addr      = r_addr;
    assign t_wdata     = r_wdata;
    assign t_we        = r_we;
    assign t_be        = r_be;

endmodule

// File: tb/tb_dmem_bus_demux.sv
// Self-checking bench for dmem_bus_demux: directed plan steps plus randomized
// transactions compared against a cycle-count model of the routing rules.
module tb_dmem_bus_demux;

    localparam int unsigned TO = 16;
    localparam logic [3:0]  RG [4] = '{4'h0, 4'h1, 4'h2, 4'h3};

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_addr;
    logic         req_we;
    logic [31:0]  req_wdata;
    logic [3:0]   req_be;
    logic         resp_valid;
    logic [31:0]  resp_rdata;
    logic         resp_err;
    logic [3:0]   t_req_valid;
    logic [3:0]   t_req_ready;
    logic [31:0]  t_addr;
    logic [31:0]  t_wdata;
    logic         t_we;
    logic [3:0]   t_be;
    logic [3:0]   t_resp_valid;
    logic [127:0] t_rdata;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_bus_demux #(
        .REGION0 (4'h0),
        .REGION1 (4'h1),
        .REGION2 (4'h2),
        .REGION3 (4'h3),
        .TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_we       (req_we),
        .req_wdata    (req_wdata),
        .req_be       (req_be),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .t_req_valid  (t_req_valid),
        .t_req_ready  (t_req_ready),
        .t_addr       (t_addr),
        .t_wdata      (t_wdata),
        .t_we         (t_we),
        .t_be         (t_be),
        .t_resp_valid (t_resp_valid),
        .t_rdata      (t_rdata)
    );

    function automatic int region_of(input logic [31:0] a);
        for (int i = 0; i < 4; i++)
            if (a[31:28] == RG[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string where);
        chk({where, "_req_ready"},   {31'b0, req_ready},   32'd1);
        chk({where, "_resp_valid"},  {31'b0, resp_valid},  32'd0);
        chk({where, "_resp_err"},    {31'b0, resp_err},    32'd0);
        chk({where, "_resp_rdata"},  resp_rdata,           32'd0);
        chk({where, "_t_req_valid"}, {28'b0, t_req_valid}, 32'd0);
        chk({where, "_t_addr"},      t_addr,               32'd0);
        chk({where, "_t_wdata"},     t_wdata,              32'd0);
        chk({where, "_t_we"},        {31'b0, t_we},        32'd0);
        chk({where, "_t_be"},        {28'b0, t_be},        32'd0);
    endtask

    // dr: cycles target withholds ready (-1 = never); ds: response delay after
    // ready (-1 = never). Model: miss -> done@1; hang -> done@TO+1; else done@3+dr+ds.
    task automatic run_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                           input logic [3:0] be, input int dr, input int ds,
                           input bit stray2, input logic [31:0] rdv);
        int sel, done, ready_c, resp_c, tv_end;
        bit err;
        logic [31:0] exp_rd;
        logic [3:0] oh;
        sel     = region_of(addr);
        oh      = (sel >= 0) ? 4'(1 << sel) : 4'b0;
        ready_c = 1 + dr;
        resp_c  = 2 + dr + ds;
        exp_rd  = '0;
        if (sel < 0) begin
            done = 1; err = 1; tv_end = 0;
        end else if (dr < 0) begin
            done = TO + 1; err = 1; tv_end = TO;
        end else if (ds < 0) begin
            done = TO + 1; err = 1; tv_end = ready_c;
        end else begin
            done = resp_c + 1; err = 0; tv_end = ready_c;
            exp_rd = we ? 32'd0 : rdv;
        end

        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = addr; req_we = we; req_wdata = wdata; req_be = be;
        t_req_ready = '0; t_resp_valid = '0;
        @(negedge clk);
        chk("accept_req_ready", {31'b0, req_ready}, 32'd1);

        for (int c = 1; c <= done + 1; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
                req_be = 4'($urandom); req_we = ~we;
            end
            t_req_ready  = 4'($urandom);
            t_resp_valid = 4'($urandom);
            t_rdata      = {$urandom, $urandom, $urandom, $urandom};
            if (sel >= 0) begin
                t_req_ready[sel] = (dr >= 0 && c == ready_c);
                if (c > tv_end && c < done) begin
                    t_resp_valid[sel] = (!err && c == resp_c);
                    if (stray2) t_resp_valid[2] = 1'b1;
                end
                if (!err && c == resp_c) t_rdata[32*sel +: 32] = rdv;
            end
            @(negedge clk);
            chk("resp_valid", {31'b0, resp_valid}, {31'b0, c == done});
            chk("req_ready", {31'b0, req_ready}, {31'b0, c == done + 1});
            chk("t_req_valid", {28'b0, t_req_valid},
                {28'b0, (sel >= 0 && c <= tv_end) ? oh : 4'b0});
            if (c == done) begin
                chk("resp_err", {31'b0, resp_err}, {31'b0, err});
                chk("resp_rdata", resp_rdata, exp_rd);
            end
            if (sel >= 0 && c <= tv_end) begin
                chk("t_addr", t_addr, addr);
                chk("t_wdata", t_wdata, wdata);
                chk("t_be", {28'b0, t_be}, {28'b0, be});
                chk("t_we", {31'b0, t_we}, {31'b0, we});
            end
        end
        t_req_ready = '0; t_resp_valid = '0;
    endtask

    task automatic start_load_t0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = 32'h0000_0010; req_we = 1'b0;
        req_wdata = 32'h0; req_be = 4'hF;
        @(negedge clk);
        chk("rst_accept", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_pre_tv", {28'b0, t_req_valid}, 32'd1);
    endtask

    initial begin
        int mode, dr, ds;
        logic [31:0] a;
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_we = 1'b0;
        req_wdata = '0; req_be = '0; t_req_ready = '0; t_resp_valid = '0; t_rdata = '0;
        #2;
        chk_reset_outputs("reset");
        @(negedge clk); rst = 1'b0;

        run_txn(32'h1000_0040, 1'b0, 32'h0, 4'hF, 0, 0, 1'b0, 32'hDEAD_BEEF);
        run_txn(32'h3000_0000, 1'b1, 32'h1234_5678, 4'b0011, 3, 0, 1'b0, 32'hCAFE_F00D);
        run_txn(32'h9000_0000, 1'b0, 32'h0, 4'hF, 0, 0, 1'b0, 32'h0);

        run_txn(32'h0000_0100, 1'b0, 32'h0, 4'hF, 0, -1, 1'b0, 32'h0);
        @(posedge clk); #1; t_resp_valid = 4'b0001;
        @(negedge clk);
        chk("late_resp_valid0", {31'b0, resp_valid}, 32'd0);
        chk("late_req_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1; t_resp_valid = '0;
        @(negedge clk);
        chk("late_resp_valid1", {31'b0, resp_valid}, 32'd0);

        run_txn(32'h2000_0008, 1'b0, 32'h0, 4'hF, -1, 0, 1'b0, 32'h0);
        run_txn(32'h0000_0200, 1'b0, 32'h0, 4'hF, 0, TO - 2, 1'b0, 32'h5A5A_A5A5);
        run_txn(32'h0000_0300, 1'b0, 32'h0, 4'hF, 1, 3, 1'b1, 32'h0BAD_CAFE);

        // Reset while in REQ, then while in RESP.
        start_load_t0();
        #1 rst = 1'b1;
        #1 chk_reset_outputs("rst_req");
        @(negedge clk); rst = 1'b0;
        start_load_t0();
        @(posedge clk); #1; t_req_ready = 4'b0001;
        @(posedge clk); #1; t_req_ready = '0;
        @(negedge clk);
        chk("rst_in_resp", {31'b0, req_ready | resp_valid}, 32'd0);
        #1 rst = 1'b1;
        #1 chk_reset_outputs("rst_resp");
        @(negedge clk); rst = 1'b0;
        run_txn(32'h1000_0004, 1'b0, 32'h0, 4'hF, 0, 1, 1'b0, 32'h1357_9BDF);

        for (int k = 0; k < 40; k++) begin
            mode = int'($urandom_range(0, 9));
            a = {4'($urandom_range(0, 3)), 28'($urandom)};
            dr = int'($urandom_range(0, 6));
            ds = int'($urandom_range(0, 6));
            if (mode == 0) a[31:28] = 4'($urandom_range(4, 15));
            if (mode == 1) dr = -1;
            if (mode == 2) ds = -1;
            run_txn(a, 1'($urandom), $urandom, 4'($urandom), dr, ds,
                    1'($urandom) && (a[31:28] != 4'h2), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
